dpe_accum: RTL
==============

DPE_ACCUM -- requirements
Module: dpe_accum

Interface
REQ-001 SHALL have parameter IDATAW, default 22: width of each signed partial dot product from the DPE chain.
REQ-002 SHALL have parameter ODATAW, default 8: width of each signed quantized output.
REQ-003 SHALL have parameter ACCW, default 32: width of each signed accumulator.
REQ-004 SHALL have parameter BATCH, default 1: number of parallel batch lanes.
REQ-005 SHALL have parameter CNTW, default 8: width of the chunk-count config.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4 (power of two): result buffer depth.
REQ-007 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port i_data[0:BATCH-1], input, IDATAW signed: partial sums, one per lane.
REQ-010 SHALL have port i_valid, input, 1: i_data valid this cycle; no backpressure upstream.
REQ-011 SHALL have port i_cfg_wr, input, 1: config write strobe.
REQ-012 SHALL have port i_cfg_chunks, input, CNTW: partial sums per output group.
REQ-013 SHALL have port i_cfg_shift, input, $clog2(ACCW): right-shift amount.
REQ-014 SHALL have port i_cfg_relu, input, 1: ReLU enable.
REQ-015 SHALL have port o_data[0:BATCH-1], output, ODATAW signed: FIFO head.
REQ-016 SHALL have port o_valid, output, 1: FIFO non-empty.
REQ-017 SHALL have port i_ready, input, 1: downstream accepts the head.
REQ-018 SHALL have port o_count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-019 SHALL have port o_overflow, output, 1: sticky flag, set when a result was dropped.

Function
REQ-020 SHALL keep a chunk counter cnt. On i_valid, each lane SHALL update acc[b] as follows, with wrap modulo 2^ACCW:
- if cnt==0: load sext(i_data[b]);
- otherwise: add sext(i_data[b]).
REQ-021 On i_valid, cnt SHALL increment, except on the last chunk, where it SHALL return to 0.
- The last chunk is cnt == max(cfg_chunks,1)-1; cfg_chunks=0 behaves as 1.
REQ-022 On the last chunk, the final sum (acc + sext(i_data), or sext(i_data) if cnt==0) SHALL be registered into a post-process stage for all lanes.
REQ-023 Post-process SHALL run in the next cycle, per lane:
- r = shift==0 ? sum : (sum + 2^(shift-1)) >>> shift (round half up, arithmetic);
- if relu and r<0, r=0;
- saturate r to [-2^(ODATAW-1), 2^(ODATAW-1)-1];
- push all BATCH values as one FIFO entry.
REQ-024 Latency SHALL be as follows: last chunk sampled at edge N -> entry written at edge N+2. If the FIFO was empty, o_valid SHALL be high and o_data SHALL equal the entry after edge N+2.
REQ-025 Back-to-back groups (cfg_chunks=1, i_valid every cycle) SHALL sustain one push per cycle.
REQ-026 The FIFO SHALL be first-word-fall-through. Pop occurs when o_valid && i_ready. o_data SHALL be 0 when empty.
REQ-027 Push when full without a simultaneous pop SHALL drop the entry, leave the contents unchanged, and set o_overflow.
REQ-028 Push and pop in the same cycle at full SHALL accept both, with no overflow and o_count unchanged.
REQ-029 Push and pop in the same cycle at empty is impossible; a push at empty SHALL become visible only after the write edge.
REQ-030 Config SHALL latch on i_cfg_wr only when cnt==0 and i_valid==0. Otherwise the write SHALL be ignored, with no error.
REQ-031 Config changes SHALL NOT affect an entry already in post-process.
REQ-032 o_overflow SHALL clear only on reset.

Reset
REQ-033 On rst low, asynchronously:
- cnt, acc, the post-process stage, the FIFO pointers, o_count and o_overflow SHALL clear to 0;
- o_valid SHALL be 0 and o_data SHALL be 0;
- config SHALL reset to chunks=1, shift=0, relu=0.
REQ-034 Reset mid-group SHALL discard the partial group; the first i_valid after release SHALL start a new group at cnt=0.
REQ-035 Reset SHALL release synchronously to clk, with no state change on the release edge.

Verification
REQ-036 Single chunk, BATCH=2, chunks=1, shift=0: i_data={5,-3} at edge N -> o_data={5,-3}, o_valid=1 after edge N+2.
REQ-037 Multi-chunk rounding, chunks=3, shift=2: inputs 10,20,30 -> output 15; inputs -2,-2,-2 -> (-6+2)>>>2 = -1.
REQ-038 Saturation and ReLU, chunks=1, shift=0:
- 300 -> 127;
- -300 -> -128;
- relu=1 with -5 -> 0.
REQ-039 Overflow, i_ready=0: five results -> o_count=4, o_overflow=1. With i_ready=1 thereafter, the first four SHALL drain in order.
REQ-040 Simultaneous push and pop at full: o_count stays 4, o_overflow stays 0, and no entry is lost.
REQ-041 Reset and config:
- rst low after 2 of 3 chunks -> all outputs 0;
- next group of 3 produces the sum of only the new inputs;
- i_cfg_wr at cnt=1 is ignored.

Source files
------------

// File: rtl/dpe_accum.sv
// Accumulates per-lane partial dot products over a configurable number of
// chunks, then rounds, optionally ReLUs, saturates and queues each group result.
module dpe_accum #(
    parameter int IDATAW     = 22,
    parameter int ODATAW     = 8,
    parameter int ACCW       = 32,
    parameter int BATCH      = 1,
    parameter int CNTW       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [IDATAW-1:0]           i_data [0:BATCH-1],
    input  logic                               i_valid,
    input  logic                               i_cfg_wr,
    input  logic [CNTW-1:0]                    i_cfg_chunks,
    input  logic [$clog2(ACCW)-1:0]            i_cfg_shift,
    input  logic                               i_cfg_relu,
    output logic signed [ODATAW-1:0]           o_data [0:BATCH-1],
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [$clog2(FIFO_DEPTH):0]        o_count,
    output logic                               o_overflow
);
    localparam int SHW = $clog2(ACCW);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((1 << (ODATAW-1)) - 1);
    localparam logic signed [ACCW:0] SAT_MIN = (ACCW+1)'(-(1 << (ODATAW-1)));

    // Extra headroom bit keeps the rounding add from wrapping.
    function automatic logic signed [ODATAW-1:0] f_post(
        input logic signed [ACCW-1:0] s,
        input logic [SHW-1:0]         sh,
        input logic                   relu
    );
        logic signed [ACCW:0] v;
        logic signed [ACCW:0] h;
        v = {s[ACCW-1], s};
        if (sh != '0) begin
            h = (ACCW+1)'(1) << (sh - 1'b1);
            v = (v + h) >>> sh;
        end
        if (relu && v < 0) v = '0;
        if (v > SAT_MAX) v = SAT_MAX;
        else if (v < SAT_MIN) v = SAT_MIN;
        return v[ODATAW-1:0];
    endfunction

    logic [CNTW-1:0]         r_cnt;
    logic [CNTW-1:0]         r_chunks;
    logic [SHW-1:0]          r_shift;
    logic                    r_relu;
    logic signed [ACCW-1:0]  r_acc [BATCH];
    logic signed [ACCW-1:0]  w_sum [BATCH];
    logic [CNTW-1:0]         w_last_idx;
    logic                    w_last;
    logic                    w_cfg_ok;

    logic                    r_s1_valid;
    logic signed [ACCW-1:0]  r_s1_sum [BATCH];
    logic [SHW-1:0]          r_s1_shift;
    logic                    r_s1_relu;
    logic                    r_s2_valid;
    logic signed [ODATAW-1:0] r_s2_data [BATCH];

    logic signed [ODATAW-1:0] r_mem [FIFO_DEPTH][BATCH];
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;

    always_comb begin
        w_last_idx = (r_chunks == '0) ? '0 : r_chunks - 1'b1;
        w_last     = (r_cnt == w_last_idx);
        w_cfg_ok   = i_cfg_wr && (r_cnt == '0) && !i_valid;
        for (int b = 0; b < BATCH; b++) begin
            w_sum[b] = ((r_cnt == '0) ? '0 : r_acc[b]) + ACCW'(i_data[b]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_chunks <= CNTW'(1);
            r_shift  <= '0;
            r_relu   <= 1'b0;
            for (int b = 0; b < BATCH; b++) r_acc[b] <= '0;
        end else begin
            if (w_cfg_ok) begin
                r_chunks <= i_cfg_chunks;
                r_shift  <= i_cfg_shift;
                r_relu   <= i_cfg_relu;
            end
            if (i_valid) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                for (int b = 0; b < BATCH; b++) r_acc[b] <= w_sum[b];
            end
        end
    end

    // Shift/relu travel with the group so later config writes cannot touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
            r_s2_valid <= 1'b0;
            for (int b = 0; b < BATCH; b++) begin
                r_s1_sum[b]  <= '0;
                r_s2_data[b] <= '0;
            end
        end else begin
            r_s1_valid <= i_valid && w_last;
            r_s2_valid <= r_s1_valid;
            if (i_valid && w_last) begin
                r_s1_shift <= r_shift;
                r_s1_relu  <= r_relu;
                for (int b = 0; b < BATCH; b++) r_s1_sum[b] <= w_sum[b];
            end
            if (r_s1_valid) begin
                for (int b = 0; b < BATCH; b++) begin
                    r_s2_data[b] <= f_post(r_s1_sum[b], r_s1_shift, r_s1_relu);
                end
            end
        end
    end

    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = o_valid && i_ready;
    assign w_push = r_s2_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int b = 0; b < BATCH; b++) r_mem[r_wr][b] <= r_s2_data[b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_s2_valid && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        o_valid    = (r_count != '0);
        o_count    = r_count;
        o_overflow = r_overflow;
        for (int b = 0; b < BATCH; b++) begin
            o_data[b] = o_valid ? r_mem[r_rd][b] : '0;
        end
    end
endmodule
